int_div: RTL
============

INT_DIV -- requirements
Module: int_div

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, giving the operand and result width in bits.
REQ-002 The module SHALL have one clock and an asynchronous, active-high reset, with ports as follows:
- clk  input  1  clock, all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  A/B valid
- in_ready  output  1  block accepts a new operand pair
- A  input  DATA_WIDTH  signed dividend
- B  input  DATA_WIDTH  signed divisor
- out_valid  output  1  Q/R/div_by_zero valid
- out_ready  input  1  consumer accepts the result
- Q  output  DATA_WIDTH  signed quotient
- R  output  DATA_WIDTH  signed remainder
- div_by_zero  output  1  set when the current result came from B == 0

Function
REQ-003 The operation SHALL be two's-complement signed division truncated toward zero: A == Q*B + R, |R| < |B|, and R takes the sign of A (R == 0 allowed).
REQ-004 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-005 in_ready SHALL be 1 exactly when state == IDLE and rst == 0; operands are accepted on a rising edge with in_valid && in_ready.
REQ-006 On accept, the block SHALL capture |A|, |B|, sign(A) and sign(A)^sign(B) internally. Later changes on A/B SHALL NOT affect the result.
REQ-007 On a normal accept (B != 0 and not the overflow case), the block SHALL:
- clear the partial remainder;
- load the iteration counter with DATA_WIDTH;
- enter CALC.
REQ-008 CALC SHALL run one restoring step per cycle, MSB first: shift the partial remainder left and bring in the next dividend bit; subtract |B|; if the difference is non-negative, keep it and set that quotient bit to 1, otherwise restore and set it to 0.
REQ-009 The subtraction in CALC SHALL be DATA_WIDTH+1 bits wide so that |A| = 2^(DATA_WIDTH-1) is handled without overflow.
REQ-010 After exactly DATA_WIDTH CALC cycles, the block SHALL:
- negate the magnitude quotient if the sign-XOR is set, and negate the magnitude remainder if sign(A) is set;
- register both into Q/R;
- enter DONE.
out_valid SHALL rise in the cycle following acceptance edge + DATA_WIDTH.
REQ-011 If B == 0 at accept, the block SHALL go directly to DONE with Q = all ones, R = A and div_by_zero = 1; out_valid is then high in the cycle right after the acceptance edge.
REQ-012 If A == most-negative and B == -1 at accept, the block SHALL go directly to DONE with Q = A, R = 0 and div_by_zero = 0.
REQ-013 In DONE, out_valid SHALL be 1, and Q, R and div_by_zero SHALL hold stable until the rising edge with out_valid && out_ready; that edge returns the FSM to IDLE.
REQ-014 The block SHALL NOT overlap operations: in_valid is ignored in CALC and DONE, and a new operand pair cannot be accepted on the same edge as the result handshake.
REQ-015 out_ready asserted outside DONE SHALL have no effect.
REQ-016 Q, R and div_by_zero SHALL change only on an entry into DONE or on reset.

Reset
REQ-017 On rst going high, immediately and independently of clk, the block SHALL:
- set state to IDLE;
- clear out_valid, Q, R, div_by_zero, the counter and the partial remainder to 0;
- drive in_ready to 0 while rst is high.
REQ-018 Reset asserted in CALC or DONE SHALL abort the operation with no result emitted. After rst falls, in_ready SHALL be 1 on the first cycle.

Verification
REQ-019 The bench SHALL cover these directed scenarios, with DATA_WIDTH = 32 unless stated:
- A=100, B=7, out_ready=1: out_valid rises 32 cycles after accept -> Q=14, R=2, div_by_zero=0.
- A=-100, B=7 -> Q=-14, R=-2; A=100, B=-7 -> Q=-14, R=2; A=-100, B=-7 -> Q=14, R=-2.
- A=5, B=0: out_valid in the next cycle -> Q=0xFFFFFFFF, R=5, div_by_zero=1. Then A=0x80000000, B=0xFFFFFFFF -> Q=0x80000000, R=0, div_by_zero=0.
- Backpressure: out_ready held 0 for 5 cycles in DONE -> out_valid stays 1, Q/R unchanged, in_ready stays 0 and in_valid pulses are ignored. Raising out_ready -> IDLE next cycle, in_ready=1.
- Reset mid-operation: rst pulsed 10 cycles into CALC -> all outputs 0 at once, no out_valid. The next operation A=0x80000000, B=3 -> Q=0xD5555556, R=-2 (0xFFFFFFFE).
- DATA_WIDTH=8, all A/B pairs checked against a reference model, including -128/-1 and /0 -> zero mismatches.

Source files
------------

// File: rtl/int_div.sv
// Signed integer divider, truncating toward zero, one restoring step per cycle.
// Divide-by-zero and most-negative/-1 bypass the iteration and finish on the accept edge.
module int_div #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Q,
  output logic [DATA_WIDTH-1:0] R,
  output logic                  div_by_zero
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nxt;

  logic [W-1:0]  dq;     // dividend bits shift out the top, quotient bits shift in the bottom
  logic [W-1:0]  bmag;
  logic [W-1:0]  rem;
  logic          sa, sq;
  logic [CW-1:0] cnt;

  logic          accept, b_zero, ovf, last;
  logic [W-1:0]  amag_in, bmag_in, qmag, rmag;
  logic [W:0]    cand, diff;

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  assign amag_in = A[W-1] ? -A : A;
  assign bmag_in = B[W-1] ? -B : B;
  assign b_zero  = (B == '0);
  assign ovf     = (A == {1'b1, {(W-1){1'b0}}}) && (B == '1);

  // rem < |B| <= 2^(W-1), so the shifted candidate always fits in W+1 bits
  assign cand = {rem, dq[W-1]};
  assign diff = cand - {1'b0, bmag};
  assign qmag = {dq[W-2:0], ~diff[W]};
  assign rmag = diff[W] ? cand[W-1:0] : diff[W-1:0];
  assign last = (cnt == CW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (b_zero || ovf) ? DONE : CALC;
      CALC:    if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dq          <= '0;
      bmag        <= '0;
      rem         <= '0;
      sa          <= 1'b0;
      sq          <= 1'b0;
      cnt         <= '0;
      Q           <= '0;
      R           <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          dq   <= amag_in;
          bmag <= bmag_in;
          sa   <= A[W-1];
          sq   <= A[W-1] ^ B[W-1];
          rem  <= '0;
          cnt  <= CW'(W);
          if (b_zero) begin
            Q           <= '1;
            R           <= A;
            div_by_zero <= 1'b1;
          end else if (ovf) begin
            Q           <= A;
            R           <= '0;
            div_by_zero <= 1'b0;
          end
        end
        CALC: begin
          dq  <= qmag;
          rem <= rmag;
          cnt <= cnt - CW'(1);
          if (last) begin
            Q           <= sq ? -qmag : qmag;
            R           <= sa ? -rmag : rmag;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
